// File: rtl/aes_key_schedule.sv
// aes_key_schedule
//   AES-128/192/256 key expansion engine. One cipher key is accepted per
//   start handshake. Expanded words are produced one per cycle (two when a
//   SubWord is needed, through a single registered 4-byte S-box path).
//   Words are packed four at a time into 128-bit round keys 0..Nr that are
//   streamed on a valid/ready port.
//
//   Optional feature macro: AES_KEY_STORE_EN adds a 15-entry round-key
//   store with a registered read port (rd_idx/rd_key) for reverse-order
//   key fetch during decryption.
//
// Ports
//   clk, reset    : clock, synchronous active-high reset
//   start         : request a new schedule, taken when start & key_ready
//   key_len       : 00=AES-128, 01=AES-192, 10=AES-256, 11 behaves as 00
//   key_in        : cipher key, MSB-aligned
//   key_ready     : engine idle, start will be accepted
//   rk_valid/rk_ready/rk_data/rk_idx : round-key stream
//   done          : one-cycle pulse after round key Nr is accepted
//   rd_idx/rd_key : store read port (AES_KEY_STORE_EN only)
//
// Handshake: a round key transfers on a rising edge where rk_valid and
// rk_ready are both high. While rk_valid is high and rk_ready low, rk_valid,
// rk_data and rk_idx hold their values.
module aes_key_schedule #(
    parameter int MAX_KEY_BITS = 256,
    parameter int RK_IDX_W     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              key_len,
    input  logic [MAX_KEY_BITS-1:0] key_in,
    output logic                    key_ready,
    output logic                    rk_valid,
    input  logic                    rk_ready,
    output logic [127:0]            rk_data,
    output logic [RK_IDX_W-1:0]     rk_idx,
    output logic                    done
`ifdef AES_KEY_STORE_EN
    ,
    input  logic [3:0]              rd_idx,
    output logic [127:0]            rd_key
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GEN, S_SUB, S_DRAIN} state_t;

    // AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        sbox = SBOX[{~x, 3'b000} +: 8];
    endfunction

    state_t                  state_q;
    logic [MAX_KEY_BITS-1:0] key_q;        // remaining key words, next at MSB
    logic [2:0]              nkm1_q;       // Nk-1
    logic [5:0]              last_word_q;  // index of final word, 4*(Nr+1)-1
    logic [5:0]              word_cnt_q;   // i
    logic [2:0]              mod_q;        // i % Nk as a wrap counter
    logic [7:0]              rcon_q;
    logic [31:0]             win_q [8];    // win_q[0] = w[i-1], win_q[Nk-1] = w[i-Nk]
    logic [31:0]             asm_q [4];
    logic [1:0]              asm_cnt_q;
    logic [RK_IDX_W-1:0]     grp_q;
    logic [31:0]             sbox_q;
    logic                    rk_valid_q;
    logic [127:0]            rk_data_q;
    logic [RK_IDX_W-1:0]     rk_idx_q;
    logic                    done_q;

    logic [31:0] temp, w_old, sbox_in, rcon_word, word;
    logic        need_sub, word_vld, out_free, grp_done, push, last_word;

    assign temp      = win_q[0];
    assign w_old     = win_q[nkm1_q];
    assign need_sub  = (mod_q == 3'd0) || (nkm1_q == 3'd7 && mod_q == 3'd4);
    assign sbox_in   = (mod_q == 3'd0) ? {temp[23:0], temp[31:24]} : temp;
    assign rcon_word = (mod_q == 3'd0) ? {rcon_q, 24'h0} : 32'h0;

    always_comb begin
        word_vld = 1'b0;
        word     = 32'h0;
        case (state_q)
            S_LOAD: begin
                word_vld = 1'b1;
                word     = key_q[MAX_KEY_BITS-1 -: 32];
            end
            S_GEN: begin
                if (!need_sub) begin
                    word_vld = 1'b1;
                    word     = w_old ^ temp;
                end
            end
            S_SUB: begin
                word_vld = 1'b1;
                word     = w_old ^ sbox_q ^ rcon_word;
            end
            default: ;
        endcase
    end

    // A completed group may only move out if the output slot is empty or is
    // being consumed this very edge; otherwise everything holds.
    assign out_free  = !rk_valid_q || rk_ready;
    assign grp_done  = word_vld && (asm_cnt_q == 2'd3);
    assign push      = word_vld && (!grp_done || out_free);
    assign last_word = (word_cnt_q == last_word_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            key_q       <= '0;
            nkm1_q      <= 3'd3;
            last_word_q <= 6'd43;
            word_cnt_q  <= '0;
            mod_q       <= '0;
            rcon_q      <= 8'h01;
            for (int k = 0; k < 8; k++) win_q[k] <= '0;
            for (int k = 0; k < 4; k++) asm_q[k] <= '0;
            asm_cnt_q   <= '0;
            grp_q       <= '0;
            sbox_q      <= '0;
            rk_valid_q  <= 1'b0;
            rk_data_q   <= '0;
            rk_idx_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (rk_valid_q && rk_ready) rk_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        key_q      <= key_in;
                        word_cnt_q <= '0;
                        mod_q      <= '0;
                        rcon_q     <= 8'h01;
                        asm_cnt_q  <= '0;
                        grp_q      <= '0;
                        state_q    <= S_LOAD;
                        case (key_len)
                            2'b01:   begin nkm1_q <= 3'd5; last_word_q <= 6'd51; end
                            2'b10:   begin nkm1_q <= 3'd7; last_word_q <= 6'd59; end
                            default: begin nkm1_q <= 3'd3; last_word_q <= 6'd43; end
                        endcase
                    end
                end
                S_GEN: begin
                    if (need_sub) begin
                        sbox_q  <= {sbox(sbox_in[31:24]), sbox(sbox_in[23:16]),
                                    sbox(sbox_in[15:8]),  sbox(sbox_in[7:0])};
                        state_q <= S_SUB;
                    end
                end
                S_DRAIN: begin
                    if (rk_valid_q && rk_ready) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: ;
            endcase

            if (push) begin
                for (int k = 7; k > 0; k--) win_q[k] <= win_q[k-1];
                win_q[0]   <= word;
                word_cnt_q <= word_cnt_q + 6'd1;
                mod_q      <= (mod_q == nkm1_q) ? 3'd0 : mod_q + 3'd1;
                if (state_q == S_LOAD) key_q <= key_q << 32;
                if (state_q == S_SUB && mod_q == 3'd0)
                    rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);

                if (grp_done) begin
                    rk_valid_q <= 1'b1;
                    rk_data_q  <= {asm_q[0], asm_q[1], asm_q[2], word};
                    rk_idx_q   <= grp_q;
                    grp_q      <= grp_q + {{(RK_IDX_W-1){1'b0}}, 1'b1};
                    asm_cnt_q  <= '0;
                end else begin
                    asm_q[asm_cnt_q] <= word;
                    asm_cnt_q        <= asm_cnt_q + 2'd1;
                end

                if (last_word)
                    state_q <= S_DRAIN;
                else if (state_q == S_SUB)
                    state_q <= S_GEN;
                else if (state_q == S_LOAD && word_cnt_q == {3'b000, nkm1_q})
                    state_q <= S_GEN;
            end
        end
    end

    assign key_ready = (state_q == S_IDLE);
    assign rk_valid  = rk_valid_q;
    assign rk_data   = rk_data_q;
    assign rk_idx    = rk_idx_q;
    assign done      = done_q;

`ifdef AES_KEY_STORE_EN
    // Store survives reset and new jobs; entries are overwritten as rounds
    // are re-emitted.
    logic [127:0] store_q [15];
    logic [127:0] rd_key_q;

    always_ff @(posedge clk) begin
        if (!reset && rk_valid_q && rk_ready && rk_idx_q <= RK_IDX_W'(14))
            store_q[rk_idx_q] <= rk_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset)
            rd_key_q <= '0;
        else
            rd_key_q <= (rd_idx <= 4'd14) ? store_q[rd_idx] : '0;
    end

    assign rd_key = rd_key_q;
`endif

endmodule
